// File: rtl/hack_rom_loader.sv
// ---------------------------------------------------------------------------
// hack_rom_loader
//
// Boot sequencer for the Hack CPU. After power-up the CPU is held in reset.
// A start pulse begins a load: a 16-bit word count N arrives first (high byte
// first), followed by N 16-bit words (each high byte first). Every assembled
// word is written into instruction ROM at consecutive addresses starting at 0.
// Once the last word is written, the CPU reset is held for RESET_HOLD more
// cycles and then released, so the CPU starts fetching at pc 0.
//
// A zero or oversize word count, or too long a pause between bytes during a
// load, aborts into ERROR with the CPU kept in reset. A new start pulse from
// IDLE, DONE or ERROR begins a fresh load.
//
// Parameters:
//   ROM_WORDS   ROM depth and largest accepted word count
//   RESET_HOLD  cycles cpu_reset_o stays high after the last ROM write (>= 1)
//   TIMEOUT     idle cycles allowed between accepted bytes during a load
//
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   rst_i        asynchronous active-high reset, clears all state
//   start_i      single-cycle pulse that begins a load
//   rx_data_i    incoming byte
//   rx_valid_i   rx_data_i is valid
//   rx_ready_o   loader accepts a byte this cycle
//   rom_we_o     ROM write strobe, one cycle per word
//   rom_addr_o   ROM write address
//   rom_wdata_o  ROM write data
//   cpu_reset_o  drives the CPU reset input
//   busy_o       a load is in progress
//   done_o       last load completed successfully
//   error_o      last load aborted
// ---------------------------------------------------------------------------
module hack_rom_loader #(
    parameter int ROM_WORDS  = 32768,
    parameter int RESET_HOLD = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        rom_we_o,
    output logic [14:0] rom_addr_o,
    output logic [15:0] rom_wdata_o,
    output logic        cpu_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [16:0]   MAX_LEN   = 17'(ROM_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    wdata_hi_q, wdata_hi_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [14:0]   rom_addr_q, rom_addr_d;
    logic [15:0]   rom_wdata_q, rom_wdata_d;
    logic          rom_we_q;
    logic          cpu_reset_q;

    logic          accept;
    logic [15:0]   len_new;
    logic [15:0]   cnt_inc;

    // The byte-receiving states are exactly the ones that raise rx_ready.
    assign rx_ready_o = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign accept     = rx_ready_o && rx_valid_i;
    assign len_new    = {len_q[15:8], rx_data_i};
    assign cnt_inc    = word_cnt_q + 16'd1;

    // Next-state logic. The ROM address/data registers are loaded on the
    // edge that enters WRITE so they are stable during the strobe and keep
    // their values afterwards. The idle timer only advances while waiting
    // for a byte; any state change (including every accepted byte) clears it.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wdata_hi_d  = wdata_hi_q;
        word_cnt_d  = word_cnt_q;
        tmo_d       = tmo_q;
        hold_d      = hold_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data_i;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    if ((len_new == 16'd0) || ({1'b0, len_new} > MAX_LEN)) begin
                        state_d = S_ERROR;
                    end else begin
                        word_cnt_d = 16'd0;
                        state_d    = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    wdata_hi_d = rx_data_i;
                    state_d    = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    rom_addr_d  = word_cnt_q[14:0];
                    rom_wdata_d = {wdata_hi_q, rx_data_i};
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                word_cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    hold_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rx_ready_o && !accept) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERROR;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    // State register. rom_we and cpu_reset come from dedicated flops fed by
    // the next state, so both are glitch-free and line up with the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wdata_hi_q  <= '0;
            word_cnt_q  <= '0;
            tmo_q       <= '0;
            hold_q      <= '0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            rom_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wdata_hi_q  <= wdata_hi_d;
            word_cnt_q  <= word_cnt_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            rom_we_q    <= (state_d == S_WRITE);
            cpu_reset_q <= (state_d != S_DONE);
        end
    end

    assign rom_we_o    = rom_we_q;
    assign rom_addr_o  = rom_addr_q;
    assign rom_wdata_o = rom_wdata_q;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) &&
                         (state_q != S_ERROR);
    assign done_o      = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERROR);

endmodule

// File: tb/tb_hack_rom_loader.sv
module tb_hack_rom_loader;

    localparam int RH  = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        romWe;
    logic [14:0] romAddr;
    logic [15:0] romWdata;
    logic        cpuReset;
    logic        busy;
    logic        done;
    logic        error;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int weCount   = 0;
    int lastWeCyc = 0;

    logic [30:0] expQ[$];

    hack_rom_loader #(
        .ROM_WORDS (32768),
        .RESET_HOLD(RH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .rx_data_i  (rxData),
        .rx_valid_i (rxValid),
        .rx_ready_o (rxReady),
        .rom_we_o   (romWe),
        .rom_addr_o (romAddr),
        .rom_wdata_o(romWdata),
        .cpu_reset_o(cpuReset),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    // Free-running clock and edge counter used for latency measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every ROM strobe must match the next expected
    // {addr,data} and must never overlap a byte handshake.
    always @(negedge clk) begin
        if (romWe === 1'b1) begin
            logic [30:0] expWord;
            weCount++;
            lastWeCyc = cyc;
            checks++;
            assert (expQ.size() > 0) else begin
                failures++;
                $error("[TB] FAIL unexpected_rom_we observed addr=0x%0h data=0x%0h expected=no write", romAddr, romWdata);
            end
            if (expQ.size() > 0) begin
                expWord = expQ.pop_front();
                checks++;
                assert ({romAddr, romWdata} === expWord) else begin
                    failures++;
                    $error("[TB] FAIL rom_write observed=0x%0h/0x%0h expected=0x%0h/0x%0h", romAddr, romWdata, expWord[30:16], expWord[15:0]);
                end
            end
            checks++;
            assert (rxReady === 1'b0) else begin
                failures++;
                $error("[TB] FAIL ready_in_write observed=%b expected=0", rxReady);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte after 'gap' idle cycles and holds it until taken.
    // Must be entered just after a rising edge; returns just after the
    // edge that accepted the byte.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit accepted = 0;
        rxValid = 1'b0;
        repeat (gap) syncEdge();
        rxData  = b;
        rxValid = 1'b1;
        for (int g = 0; g < 200 && !accepted; g++) begin
            @(negedge clk);
            if (rxReady === 1'b1) accepted = 1;
            syncEdge();
        end
        rxValid = 1'b0;
        checkOutput("byte_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic sendWord(input logic [14:0] addr, input logic [15:0] w, input int gap);
        logic [15:0] wv;
        wv = w;
        expQ.push_back({addr, wv});
        applyStimulus(wv[15:8], gap);
        applyStimulus(wv[7:0], gap);
    endtask

    task automatic pulseStart(output int s);
        start = 1'b1;
        syncEdge();
        start = 1'b0;
        s = cyc;
    endtask

    task automatic waitDone(output int c);
        c = -1;
        for (int g = 0; g < 200 && c < 0; g++) begin
            @(negedge clk);
            if (done === 1'b1) c = cyc;
        end
        checkOutput("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic waitError(output int c);
        c = -1;
        for (int g = 0; g < 200 && c < 0; g++) begin
            @(negedge clk);
            if (error === 1'b1) c = cyc;
        end
        checkOutput("error_reached", {31'd0, error}, 32'd1);
    endtask

    task automatic waitCpuRelease(output int c);
        c = -1;
        for (int g = 0; g < 200 && c < 0; g++) begin
            @(negedge clk);
            if (cpuReset === 1'b0) c = cyc;
        end
        checkOutput("cpu_released", {31'd0, cpuReset}, 32'd0);
    endtask

    initial begin
        int s;
        int c;
        int a;
        int weBefore;

        rst     = 1'b0;
        start   = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        #1 rst  = 1'b1;
        #11;

        // Reset values while reset is asserted.
        checkOutput("rst_rx_ready",  {31'd0, rxReady},  32'd0);
        checkOutput("rst_rom_we",    {31'd0, romWe},    32'd0);
        checkOutput("rst_rom_addr",  {17'd0, romAddr},  32'd0);
        checkOutput("rst_rom_wdata", {16'd0, romWdata}, 32'd0);
        checkOutput("rst_cpu_reset", {31'd0, cpuReset}, 32'd1);
        checkOutput("rst_busy",      {31'd0, busy},     32'd0);
        checkOutput("rst_done",      {31'd0, done},     32'd0);
        checkOutput("rst_error",     {31'd0, error},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) syncEdge();
        checkOutput("idle_cpu_reset", {31'd0, cpuReset}, 32'd1);

        // Basic back-to-back load of two words.
        $display("[TB] basic load");
        pulseStart(s);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        sendWord(15'd0, 16'h0005, 0);
        sendWord(15'd1, 16'hEC10, 0);
        waitCpuRelease(c);
        checkOutput("reset_hold_gap", c - (lastWeCyc + 1), RH);
        checkOutput("load_time", c - s, 2 + 3 * 2 + RH);
        checkOutput("basic_done", {31'd0, done}, 32'd1);
        checkOutput("basic_busy", {31'd0, busy}, 32'd0);
        checkOutput("basic_sb_empty", expQ.size(), 0);

        // Same stream with rx_valid only present one cycle in three.
        $display("[TB] backpressure load");
        weBefore = weCount;
        pulseStart(s);
        applyStimulus(8'h00, 2);
        applyStimulus(8'h02, 2);
        sendWord(15'd0, 16'h0005, 2);
        sendWord(15'd1, 16'hEC10, 2);
        waitDone(c);
        checkOutput("bp_writes", weCount - weBefore, 2);
        checkOutput("bp_sb_empty", expQ.size(), 0);

        // Zero and oversize lengths abort without touching ROM.
        $display("[TB] bad lengths");
        weBefore = weCount;
        pulseStart(s);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        waitError(c);
        checkOutput("len0_time", c - s, 2);
        checkOutput("len0_cpu_reset", {31'd0, cpuReset}, 32'd1);
        checkOutput("len0_busy", {31'd0, busy}, 32'd0);
        checkOutput("len0_done", {31'd0, done}, 32'd0);
        pulseStart(s);
        applyStimulus(8'h80, 0);
        applyStimulus(8'h01, 0);
        waitError(c);
        checkOutput("len32769_time", c - s, 2);
        checkOutput("len32769_cpu_reset", {31'd0, cpuReset}, 32'd1);
        checkOutput("badlen_writes", weCount - weBefore, 0);

        // Exactly ROM_WORDS is accepted; let the idle timer abort it.
        pulseStart(s);
        applyStimulus(8'h80, 0);
        applyStimulus(8'h00, 0);
        a = cyc;
        @(negedge clk);
        checkOutput("maxlen_error", {31'd0, error}, 32'd0);
        checkOutput("maxlen_ready", {31'd0, rxReady}, 32'd1);
        waitError(c);
        checkOutput("maxlen_timeout", c - a, TMO);

        // Timeout partway through the first data word.
        $display("[TB] timeout");
        weBefore = weCount;
        pulseStart(s);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h00, 0);
        a = cyc;
        waitError(c);
        checkOutput("timeout_latency", c - a, TMO);
        checkOutput("timeout_writes", weCount - weBefore, 0);
        checkOutput("timeout_cpu_reset", {31'd0, cpuReset}, 32'd1);
        pulseStart(s);
        @(negedge clk);
        checkOutput("restart_error", {31'd0, error}, 32'd0);
        checkOutput("restart_busy", {31'd0, busy}, 32'd1);
        syncEdge();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        sendWord(15'd0, 16'hBEEF, 0);
        waitDone(c);
        checkOutput("restart_sb_empty", expQ.size(), 0);

        // Asynchronous reset between the two bytes of word 1.
        $display("[TB] reset mid-load");
        syncEdge();
        weBefore = weCount;
        pulseStart(s);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        sendWord(15'd0, 16'h1234, 0);
        applyStimulus(8'hAA, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_cpu_reset", {31'd0, cpuReset}, 32'd1);
        checkOutput("arst_busy",      {31'd0, busy},     32'd0);
        checkOutput("arst_rx_ready",  {31'd0, rxReady},  32'd0);
        checkOutput("arst_rom_we",    {31'd0, romWe},    32'd0);
        checkOutput("arst_rom_addr",  {17'd0, romAddr},  32'd0);
        checkOutput("arst_rom_wdata", {16'd0, romWdata}, 32'd0);
        checkOutput("arst_done",      {31'd0, done},     32'd0);
        checkOutput("arst_error",     {31'd0, error},    32'd0);
        rxData  = 8'h55;
        rxValid = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxValid = 1'b0;
        @(negedge clk);
        checkOutput("arst_idle_ready", {31'd0, rxReady}, 32'd0);
        checkOutput("arst_idle_cpu", {31'd0, cpuReset}, 32'd1);
        checkOutput("arst_writes", weCount - weBefore, 1);
        checkOutput("arst_sb_empty", expQ.size(), 0);

        // Re-load from DONE, with start pulses while busy.
        $display("[TB] reload");
        pulseStart(s);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        sendWord(15'd0, 16'h0ABC, 0);
        waitDone(c);
        checkOutput("reload_pre_cpu", {31'd0, cpuReset}, 32'd0);
        weBefore = weCount;
        pulseStart(s);
        @(negedge clk);
        checkOutput("reload_cpu_reset", {31'd0, cpuReset}, 32'd1);
        checkOutput("reload_done", {31'd0, done}, 32'd0);
        checkOutput("reload_busy", {31'd0, busy}, 32'd1);
        syncEdge();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        expQ.push_back({15'd0, 16'h1234});
        applyStimulus(8'h12, 0);
        start = 1'b1;
        syncEdge();
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_start_busy", {31'd0, busy}, 32'd1);
        checkOutput("busy_start_ready", {31'd0, rxReady}, 32'd1);
        syncEdge();
        start = 1'b1;
        applyStimulus(8'h34, 0);
        start = 1'b0;
        waitDone(c);
        checkOutput("reload_writes", weCount - weBefore, 1);
        checkOutput("reload_final_cpu", {31'd0, cpuReset}, 32'd0);
        checkOutput("reload_sb_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
Boot sequencer for the Hack CPU. Holds the CPU in reset, receives a program as a length-prefixed byte stream over a valid/ready interface, and writes it word-by-word into instruction ROM. It then releases CPU reset so execution starts at pc 0. It sits between the host/UART byte receiver and the ROM write port, and owns the CPU's reset input.

Parameters:
ROM_WORDS, 32768, instruction ROM depth; maximum accepted program length.
RESET_HOLD, 4, cycles cpu_reset stays high after the last ROM write (min 1).
TIMEOUT, 1000000, idle cycles allowed between accepted bytes during a load before ERROR.

Ports:
CLK  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  single-cycle pulse; begins a load
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  loader accepts a byte this cycle
rom_we  output  1  ROM write strobe, one cycle per word
rom_addr  output  15  ROM write address
rom_wdata  output  16  ROM write data
cpu_reset  output  1  drives the CPU reset input
busy  output  1  load in progress (LEN_HI through HOLD)
done  output  1  last load completed successfully
error  output  1  last load aborted

Behaviour:
- Reset values: rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_reset=1, busy=0, done=0, error=0, state=IDLE. After power-up the CPU stays in reset until a successful load.
- Byte transfer: accepted only on a cycle where rx_valid && rx_ready. rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
- Stream format: 2-byte word count N (high byte first), then N words, each high byte first.
- States:
  - IDLE: start -> LEN_HI; cpu_reset=1, done=0, error=0 on the next cycle.
  - LEN_HI: accept byte -> len[15:8]; -> LEN_LO.
  - LEN_LO: accept byte -> len[7:0]. If N==0 or N>ROM_WORDS -> ERROR. Otherwise clear word count, -> DATA_HI.
  - DATA_HI: accept byte -> wdata[15:8]; -> DATA_LO.
  - DATA_LO: accept byte -> wdata[7:0]; -> WRITE.
  - WRITE: exactly one cycle. rom_we=1, rom_addr=word count, rom_wdata=assembled word, rx_ready=0. Word count increments. If new count==N -> HOLD, else -> DATA_HI.
  - HOLD: cpu_reset=1 for RESET_HOLD cycles, then -> DONE.
  - DONE: cpu_reset=0, done=1, busy=0. start -> LEN_HI (re-load; cpu_reset reasserted on the next cycle).
  - ERROR: error=1, cpu_reset=1, busy=0. start -> LEN_HI (error cleared).
- Latency: the first ROM write occurs 1 cycle after the 4th accepted byte. Each subsequent word adds 1 cycle after its 2nd byte. Minimum load time for N words is 2+3N+RESET_HOLD cycles after start.
- Timeout: a counter runs in LEN_HI..DATA_LO, clears on every accepted byte and on state entry, and holds in WRITE/HOLD. Reaching TIMEOUT -> ERROR.
- start while busy=1 is ignored. A start coinciding with an accepted byte is ignored.
- rom_addr wraps never: N is bounded by ROM_WORDS, and the last address written is N-1.
- Async reset mid-load: immediate return to IDLE with cpu_reset=1. Partial ROM contents are not cleared.
- rom_addr and rom_wdata hold their last values outside WRITE. rom_we is registered, never combinational from rx_valid.
- cpu_reset is registered and glitch-free.

Test Plan:
- Basic load: after reset, pulse start; stream 00 02 | 00 05 | EC 10 with rx_valid held high. Required: rom_we pulses at addr 0 (data 0x0005) and addr 1 (data 0xEC10); cpu_reset falls exactly RESET_HOLD=4 cycles after the 2nd write; then done=1 and busy=0.
- Backpressure/gaps: same stream with rx_valid toggling 1-of-3 cycles. Required: identical ROM writes, no bytes dropped or duplicated, rx_ready low during WRITE.
- Bad length: stream 00 00. Required: ERROR, error=1, cpu_reset stays 1, no rom_we. Stream 80 01 (32769 > ROM_WORDS) gives the same response.
- Timeout (TIMEOUT=16 in bench): send 00 03 00. Then hold rx_valid=0. Required: ERROR 16 cycles after the last accepted byte, only 0 words written. start then restarts cleanly and error clears.
- Reset mid-load: assert reset asynchronously between DATA_HI and DATA_LO of word 1. Required: outputs return to reset values immediately, without waiting for a clock edge; cpu_reset=1; no further rom_we.
- Re-load from DONE: after a successful load, pulse start; also pulse start during busy. Required: the first pulse sets cpu_reset=1 and done=0 on the next cycle; the busy-time pulse has no effect on state or counters.
